// File: rtl/mux_rr_arbiter_pkg.sv
// mux_rr_arbiter_pkg
// Shared definitions for the round-robin mux arbiter: sizes, the arbiter
// state encoding and the round-robin priority pick function.
package mux_rr_arbiter_pkg;

    localparam int NUM_SRC = 4;
    localparam int SEL_W   = 2;
    localparam int WIDTH   = 17;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_t;

    // Return the first set bit of eff, scanning ptr, ptr+1, ... with the
    // index wrapping modulo NUM_SRC (natural SEL_W-bit wrap). When eff is
    // empty the result is ptr, but callers only use it when eff != 0.
    function automatic logic [SEL_W-1:0] rr_pick(
        input logic [NUM_SRC-1:0] eff,
        input logic [SEL_W-1:0]   ptr
    );
        logic [SEL_W-1:0] win;
        logic [SEL_W-1:0] idx;
        logic             found;
        win   = ptr;
        found = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            idx   = ptr + SEL_W'(i);
            win   = (!found && eff[idx]) ? idx : win;
            found = found | eff[idx];
        end
        return win;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_mux.sv
// mux
// The shared 4:1 selection mux.
// Ports:
//   i0..i3  in  WIDTH  candidate words
//   select  in  2      index of the word to pass through
//   d       out WIDTH  selected word (combinational)
module mux #(
    parameter int WIDTH = 17
) (
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic [1:0]       select,
    output logic [WIDTH-1:0] d
);

    // Pure 4:1 selection.
    always_comb begin
        d = {WIDTH{1'b0}};
        case (select)
            2'd0:    d = i0;
            2'd1:    d = i1;
            2'd2:    d = i2;
            2'd3:    d = i3;
            default: d = {WIDTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
// Round-robin arbiter sharing one 4:1 mux among four sources. A winner is
// picked in IDLE, its word is captured through the mux in LOAD and offered
// downstream on a valid/ready handshake in SEND; acceptance acks the source.
// Ports:
//   clk        in   1      system clock, rising edge
//   rst        in   1      asynchronous active-high reset
//   req        in   4      per-source request
//   din0..din3 in   WIDTH  per-source data
//   sel        out  2      current grant index, drives the mux select
//   out_data   out  WIDTH  registered selected word
//   out_valid  out  1      out_data valid
//   out_ready  in   1      consumer accepts when high with out_valid
//   ack        out  4      one-cycle pulse for the accepted source
//   busy       out  1      high whenever the arbiter is not idle
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int WIDTH   = mux_rr_arbiter_pkg::WIDTH,
    parameter int NUM_SRC = mux_rr_arbiter_pkg::NUM_SRC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] req,
    input  logic [WIDTH-1:0]   din0,
    input  logic [WIDTH-1:0]   din1,
    input  logic [WIDTH-1:0]   din2,
    input  logic [WIDTH-1:0]   din3,
    output logic [SEL_W-1:0]   sel,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUM_SRC-1:0] ack,
    output logic               busy
);

    state_t             state;
    state_t             next_state;
    logic [SEL_W-1:0]   ptr;
    logic [NUM_SRC-1:0] eff;
    logic [SEL_W-1:0]   winner;
    logic [WIDTH-1:0]   mux_d;
    logic               handshake;

    // A source in its ack cycle is masked so it cannot be re-granted at once.
    assign eff       = req & ~ack;
    assign winner    = rr_pick(eff, ptr);
    assign handshake = (state == SEND) && out_valid && out_ready;
    assign busy      = (state != IDLE);

    mux #(.WIDTH(WIDTH)) u_mux (
        .i0     (din0),
        .i1     (din1),
        .i2     (din2),
        .i3     (din3),
        .select (sel),
        .d      (mux_d)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (eff != {NUM_SRC{1'b0}}) begin
                    next_state = LOAD;
                end else begin
                    next_state = IDLE;
                end
            end
            LOAD: next_state = SEND;
            SEND: begin
                if (handshake) begin
                    next_state = IDLE;
                end else begin
                    next_state = SEND;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Grant index, pointer, captured word, valid flag and ack pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel       <= {SEL_W{1'b0}};
            ptr       <= {SEL_W{1'b0}};
            out_data  <= {WIDTH{1'b0}};
            out_valid <= 1'b0;
            ack       <= {NUM_SRC{1'b0}};
        end else begin
            ack <= {NUM_SRC{1'b0}};
            case (state)
                IDLE: begin
                    if (eff != {NUM_SRC{1'b0}}) begin
                        sel <= winner;
                    end
                end
                LOAD: begin
                    out_data  <= mux_d;
                    out_valid <= 1'b1;
                end
                SEND: begin
                    if (handshake) begin
                        out_valid <= 1'b0;
                        ack[sel]  <= 1'b1;
                        // SEL_W-bit add wraps 3 back to 0.
                        ptr       <= sel + 2'd1;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic [16:0] din0 = 17'h0, din1 = 17'h0, din2 = 17'h0, din3 = 17'h0;
    logic        out_ready = 1'b0;
    logic [1:0]  sel;
    logic [16:0] out_data;
    logic        out_valid;
    logic [3:0]  ack;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mux_rr_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .din0      (din0),
        .din1      (din1),
        .din2      (din2),
        .din3      (din3),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ack       (ack),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase 0: waiting for requests, 1: word being fetched, 2: word offered
    int         m_phase = 0;
    int         m_sel   = 0;
    int         m_ptr   = 0;
    logic [16:0] m_data = 17'h0;
    logic       m_valid = 1'b0;
    logic [3:0] m_ack   = 4'b0000;

    function automatic int model_pick(input logic [3:0] e, input int p);
        for (int d = 0; d < 4; d++) begin
            if (e[(p + d) % 4]) return (p + d) % 4;
        end
        return p;
    endfunction

    function automatic logic [16:0] src_word(input int i);
        case (i)
            0: return din0;
            1: return din1;
            2: return din2;
            default: return din3;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_sel   <= 0;
            m_ptr   <= 0;
            m_data  <= 17'h0;
            m_valid <= 1'b0;
            m_ack   <= 4'b0000;
        end else begin
            m_ack <= 4'b0000;
            if (m_phase == 0) begin
                if ((req & ~m_ack) != 4'b0000) begin
                    m_sel   <= model_pick(req & ~m_ack, m_ptr);
                    m_phase <= 1;
                end
            end else if (m_phase == 1) begin
                m_data  <= src_word(m_sel);
                m_valid <= 1'b1;
                m_phase <= 2;
            end else begin
                if (out_ready) begin
                    m_valid <= 1'b0;
                    m_ack   <= 4'b0001 << m_sel;
                    m_ptr   <= (m_sel + 1) % 4;
                    m_phase <= 0;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("m_sel",       {30'd0, sel},       m_sel);
        check("m_out_data",  {15'd0, out_data},  {15'd0, m_data});
        check("m_out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        check("m_ack",       {28'd0, ack},       {28'd0, m_ack});
        check("m_busy",      {31'd0, busy},      (m_phase != 0) ? 32'd1 : 32'd0);
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [3:0] seen [$];

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        check("rst_sel",   {30'd0, sel},       32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_ack",   {28'd0, ack},       32'd0);
        check("rst_busy",  {31'd0, busy},      32'd0);
        check("rst_data",  {15'd0, out_data},  32'd0);
        rst = 1'b0;

        // single request from source 2
        req = 4'b0100; din2 = 17'h1ABCD; out_ready = 1'b1;
        @(negedge clk);
        check("t1_sel",   {30'd0, sel},  32'd2);
        check("t1_busy",  {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("t1_valid", {31'd0, out_valid}, 32'd1);
        check("t1_data",  {15'd0, out_data},  32'h1ABCD);
        @(negedge clk);
        check("t1_ack",   {28'd0, ack},  32'h4);
        check("t1_idle",  {31'd0, busy}, 32'd0);
        req = 4'b0000;
        @(negedge clk);
        check("t1_ackclr", {28'd0, ack}, 32'h0);

        // all four requesting: grant order 0,1,2,3,0
        do_reset();
        din0 = 17'h00010; din1 = 17'h00111; din2 = 17'h00222; din3 = 17'h10333;
        req = 4'b1111; out_ready = 1'b1;
        seen.delete();
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (ack != 4'b0000) seen.push_back(ack);
        end
        check("t2_count", seen.size(), 32'd5);
        if (seen.size() == 5) begin
            check("t2_g0", {28'd0, seen[0]}, 32'h1);
            check("t2_g1", {28'd0, seen[1]}, 32'h2);
            check("t2_g2", {28'd0, seen[2]}, 32'h4);
            check("t2_g3", {28'd0, seen[3]}, 32'h8);
            check("t2_g4", {28'd0, seen[4]}, 32'h1);
        end

        // lone source held high: masked in its ack cycle, one grant per 4 cycles
        do_reset();
        req = 4'b0001;
        seen.delete();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (ack != 4'b0000) seen.push_back(ack);
        end
        check("t2b_count", seen.size(), 32'd3);

        // stall with out_ready=0, din1 changes after capture
        do_reset();
        req = 4'b0010; din1 = 17'h00A5A; out_ready = 1'b0;
        @(negedge clk);
        check("t3_sel", {30'd0, sel}, 32'd1);
        @(negedge clk);
        din1 = 17'h15555;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t3_hold_data",  {15'd0, out_data},  32'h00A5A);
            check("t3_hold_valid", {31'd0, out_valid}, 32'd1);
            check("t3_hold_sel",   {30'd0, sel},       32'd1);
            check("t3_hold_ack",   {28'd0, ack},       32'h0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("t3_ack", {28'd0, ack}, 32'h2);
        req = 4'b0000;

        // grant to 2 leaves ptr at 3; then 4'b1001 resolves 3 before 0
        @(negedge clk);
        req = 4'b0100;
        repeat (3) @(negedge clk);
        check("t4_ack2", {28'd0, ack}, 32'h4);
        req = 4'b1001;
        seen.delete();
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (ack != 4'b0000) seen.push_back(ack);
        end
        check("t4_count", seen.size(), 32'd2);
        if (seen.size() == 2) begin
            check("t4_first",  {28'd0, seen[0]}, 32'h8);
            check("t4_second", {28'd0, seen[1]}, 32'h1);
        end
        req = 4'b0000;

        // async reset during SEND
        do_reset();
        req = 4'b0010; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_pre_valid", {31'd0, out_valid}, 32'd1);
        #1 rst = 1'b1;
        #2;
        check("t5_valid", {31'd0, out_valid}, 32'd0);
        check("t5_ack",   {28'd0, ack},       32'h0);
        check("t5_sel",   {30'd0, sel},       32'd0);
        check("t5_data",  {15'd0, out_data},  32'h0);
        check("t5_busy",  {31'd0, busy},      32'd0);
        req = 4'b0000; out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("t5_noack", {28'd0, ack}, 32'h0);
        end

        // source 0 drops req during LOAD; transfer still completes
        do_reset();
        din0 = 17'h0F0F0; req = 4'b0001; out_ready = 1'b1;
        @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
        check("t6_valid", {31'd0, out_valid}, 32'd1);
        check("t6_data",  {15'd0, out_data},  32'h0F0F0);
        @(negedge clk);
        check("t6_ack",   {28'd0, ack},       32'h1);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
Round-robin arbiter that shares the 4:1, 17-bit selection mux (`mux`) among four requesting sources.
- Picks one requester, drives the mux select, and captures the selected word into an output register.
- Presents the word downstream on a valid/ready handshake and acks the winning source.
- Sits between the four data producers (e.g. display/result sources) and the single shared consumer.

Parameters:
- WIDTH, 17, data width of each source and of out_data; must match the mux width.
- NUM_SRC, 4, number of requesters; fixed at 4 because select is 2 bits.

Ports:
- clk  in  1  single system clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- req  in  4  req[i] high = source i has a word on din_i
- din0  in  WIDTH  source 0 data
- din1  in  WIDTH  source 1 data
- din2  in  WIDTH  source 2 data
- din3  in  WIDTH  source 3 data
- sel  out  2  current grant index; drives the mux select
- out_data  out  WIDTH  registered selected word
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts out_data when high with out_valid
- ack  out  4  one-cycle pulse on ack[i] when source i's word is accepted
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, immediate): state=IDLE, sel=0, ptr=0, out_data=0, out_valid=0, ack=0, busy=0.
- Reset mid-transfer discards the in-flight word and issues no ack.
- Effective request vector: eff = req & ~ack. This blocks re-granting a source during its ack cycle.
- State IDLE:
  - If eff==0, stay in IDLE.
  - Otherwise winner = first set bit of eff scanning ptr, ptr+1, ... mod 4.
  - Register sel<=winner and go to LOAD.
- State LOAD:
  - out_data<=mux output (din_sel), out_valid<=1, go to SEND.
  - sel is stable for the whole of LOAD.
- State SEND:
  - Hold out_data, out_valid and sel stable while out_ready==0. No timeout.
  - On an edge with out_valid && out_ready: out_valid<=0, ack[sel]<=1, ptr<=(sel+1) mod 4 (3 wraps to 0), state<=IDLE.
- ack is high for exactly one cycle and is cleared on the next edge. At most one ack bit is set at a time.
- Latency:
  - req sampled high at edge k in IDLE → sel updated after edge k.
  - out_valid high after edge k+1.
  - Earliest handshake at edge k+2; ack visible after edge k+2.
- Throughput: one transfer per 3 cycles under continuous requests with out_ready=1.
- Sources must hold req and din stable until their ack.
  - Dropping req after grant (LOAD/SEND) does not abort; the captured word still completes.
  - din changes after LOAD are ignored.
- Simultaneous requests are resolved only by ptr order. Lower index never has fixed priority.
- Changes to req while in LOAD/SEND are not sampled until the return to IDLE.
- sel changes only on the IDLE→LOAD transition and on reset.

Decomposition:
- Shared package:
  - State encoding constants: IDLE=2'd0, LOAD=2'd1, SEND=2'd2.
  - NUM_SRC=4, SEL_W=2, WIDTH=17.
- Sub-module: instantiate the existing 4:1 mux (`mux`), with din0..din3 to i0..i3, sel to select, and its d output feeding the out_data capture register.
- Round-robin priority pick: a combinational function inside the arbiter, not a separate module.

Test Plan:
- Reset, then req=4'b0100, din2=17'h1ABCD, out_ready=1 → sel=2 one cycle after sampling; out_valid with out_data=17'h1ABCD next cycle; ack=4'b0100 for one cycle; busy then low.
- req=4'b1111 held, each source re-asserting after its ack, out_ready=1 → grant order 0,1,2,3,0; each ack a single pulse; no source granted in its own ack cycle.
- Grant to source 1 with out_ready=0 for 5 cycles, din1 changed meanwhile → out_data and sel stay unchanged, out_valid held high; handshake on the 6th cycle acks only source 1 with the originally captured word.
- ptr=3 (after a grant to source 2), req=4'b1001 → source 3 wins first, then source 0; ptr wraps 3→0.
- Assert rst during SEND → out_valid, ack, sel, out_data, busy all 0 immediately without a clock edge; no ack is ever issued for the discarded word.
- Source 0 granted, then drops req during LOAD → word still presented and accepted; ack[0] still pulses.
